// File: rtl/vslc_pkg.sv
// Shared state encoding and constants for the VSLC scan sequencer.
package vslc_pkg;

   typedef enum logic [2:0] {
      HDR,
      RUN,
      WAIT,
      RESTART,
      FAULT
   } state_t;

   localparam logic [1:0] FC_NONE     = 2'd0;
   localparam logic [1:0] FC_END_ZERO = 2'd1;
   localparam logic [1:0] FC_RANGE    = 2'd2;
   localparam logic [1:0] FC_WDT      = 2'd3;

   localparam int HDR_BYTES = 4;

endpackage

// File: rtl/vslc_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge detector.
module vslc_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic [1:0] sync_reg;
   logic       prev_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg <= 2'b00;
         prev_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[0], din};
         prev_reg <= sync_reg[1];
      end
   end

   assign rise = sync_reg[1] & ~prev_reg;

endmodule

// File: rtl/vslc_scan_sequencer.sv
// Turns the EEPROM byte stream into repeating PLC scans: header parse, forwarding, restarts.
// Optional byte-starvation watchdog is built when VSLC_SCAN_WDT_EN is defined.
module vslc_scan_sequencer
   import vslc_pkg::*;
#(
   parameter int ADDR_W        = 10,
   parameter int MIN_PERIOD    = 256,
   parameter int RESTART_PULSE = 2
`ifdef VSLC_SCAN_WDT_EN
   ,
   parameter int WDT_CYCLES    = 4096
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic [15:0] byte_addr,
   input  logic        exec_busy,
   input  logic        auto_mode,
   input  logic        ext_trigger,
   output logic        restart,
   output logic [15:0] start_addr,
   output logic        hold_n,
   output logic        instr_valid,
   output logic [7:0]  instr_byte,
   output logic        scan_start,
   output logic        scan_active,
   output logic [15:0] scan_count,
   output logic        fault,
   output logic [1:0]  fault_code,
   output logic        trig_overrun
);

   localparam int PULSE_W = (RESTART_PULSE > 1) ? $clog2(RESTART_PULSE) : 1;
   localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RESTART_PULSE - 1);

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   start_reg, end_reg;
   logic                hdr_check_reg;
   logic [15:0]         period_reg;
   logic [PULSE_W-1:0]  pulse_cnt_reg;
   logic                pending_reg, overrun_reg;
   logic                hold_n_reg, instr_valid_reg, scan_start_reg, scan_active_reg;
   logic [7:0]          instr_byte_reg;
   logic [15:0]         scan_count_reg;
   logic                fault_reg;
   logic [1:0]          fault_code_reg, fault_code_next;

   logic trig_rise, period_ok, permit;
   logic hdr_end_zero, hdr_range_bad, hdr_ok;
   logic run_byte, end_hit, pulse_done, scan_begin;

   vslc_sync_edge u_trig_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (ext_trigger),
      .rise (trig_rise)
   );

   generate
      if (MIN_PERIOD == 0) begin : g_no_rate_limit
         assign period_ok = 1'b1;
      end else begin : g_rate_limit
         assign period_ok = (period_reg >= 16'(MIN_PERIOD));
      end
   endgenerate

   assign hdr_end_zero  = (end_reg == '0);
   assign hdr_range_bad = (end_reg < start_reg) || (start_reg < ADDR_W'(HDR_BYTES));
   assign hdr_ok        = (state_reg == HDR) && hdr_check_reg && !hdr_end_zero && !hdr_range_bad;

   // A byte landing in the header-check cycle already belongs to the program.
   assign run_byte   = byte_valid && ((state_reg == RUN) || hdr_ok);
   assign end_hit    = run_byte && (byte_addr >= 16'(end_reg));
   assign pulse_done = (state_reg == RESTART) && (pulse_cnt_reg == PULSE_LAST);
   assign scan_begin = hdr_ok || pulse_done;
   assign permit     = (state_reg == WAIT) && period_ok && (auto_mode || pending_reg);

`ifdef VSLC_SCAN_WDT_EN
   localparam int WDT_W = $clog2(WDT_CYCLES + 1);

   logic [WDT_W-1:0] wdt_cnt_reg;
   logic             wdt_run, wdt_expire;

   assign wdt_run    = ((state_reg == HDR) || (state_reg == RUN)) && hold_n_reg;
   assign wdt_expire = wdt_run && !byte_valid && (wdt_cnt_reg >= WDT_W'(WDT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdt_cnt_reg <= '0;
      end else if (byte_valid || !((state_reg == HDR) || (state_reg == RUN))) begin
         wdt_cnt_reg <= '0;
      end else if (wdt_run) begin
         wdt_cnt_reg <= wdt_cnt_reg + WDT_W'(1);
      end
   end
`endif

   always_comb begin
      state_next      = state_reg;
      fault_code_next = fault_code_reg;
      case (state_reg)
         HDR: begin
            if (hdr_check_reg) begin
               if (hdr_end_zero) begin
                  state_next      = FAULT;
                  fault_code_next = FC_END_ZERO;
               end else if (hdr_range_bad) begin
                  state_next      = FAULT;
                  fault_code_next = FC_RANGE;
               end else if (end_hit) begin
                  state_next = WAIT;
               end else begin
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            if (end_hit) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (permit) begin
               state_next = RESTART;
            end
         end
         RESTART: begin
            if (pulse_done) begin
               state_next = RUN;
            end
         end
         FAULT: begin
            state_next = FAULT;
         end
         default: begin
            state_next = FAULT;
         end
      endcase
`ifdef VSLC_SCAN_WDT_EN
      if (wdt_expire && (state_next != FAULT)) begin
         state_next      = FAULT;
         fault_code_next = FC_WDT;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= HDR;
         start_reg       <= '0;
         end_reg         <= '0;
         hdr_check_reg   <= 1'b0;
         period_reg      <= '0;
         pulse_cnt_reg   <= '0;
         pending_reg     <= 1'b0;
         overrun_reg     <= 1'b0;
         hold_n_reg      <= 1'b1;
         instr_valid_reg <= 1'b0;
         instr_byte_reg  <= '0;
         scan_start_reg  <= 1'b0;
         scan_active_reg <= 1'b0;
         scan_count_reg  <= '0;
         fault_reg       <= 1'b0;
         fault_code_reg  <= FC_NONE;
      end else begin
         state_reg <= state_next;

         // Header layout: start high, start low, end high, end low.
         if ((state_reg == HDR) && byte_valid) begin
            case (byte_addr)
               16'd0:   start_reg[ADDR_W-1:8] <= byte_data[ADDR_W-9:0];
               16'd1:   start_reg[7:0]        <= byte_data;
               16'd2:   end_reg[ADDR_W-1:8]   <= byte_data[ADDR_W-9:0];
               16'd3:   end_reg[7:0]          <= byte_data;
               default: ;
            endcase
         end
         hdr_check_reg <= (state_reg == HDR) && byte_valid &&
                          (byte_addr == 16'(HDR_BYTES - 1));

         if (scan_begin) begin
            period_reg <= '0;
         end else if (period_reg != 16'hFFFF) begin
            period_reg <= period_reg + 16'd1;
         end

         pulse_cnt_reg <= (state_reg == RESTART) ? pulse_cnt_reg + PULSE_W'(1) : '0;

         // A trigger coinciding with a permitted restart is absorbed by that restart.
         if (permit) begin
            pending_reg <= 1'b0;
         end else if (trig_rise) begin
            pending_reg <= 1'b1;
         end
         if (trig_rise && pending_reg) begin
            overrun_reg <= 1'b1;
         end

         hold_n_reg      <= !((state_next == RUN) && exec_busy);
         instr_valid_reg <= run_byte;
         if (run_byte) begin
            instr_byte_reg <= byte_data;
         end
         scan_start_reg  <= scan_begin;
         scan_active_reg <= (state_next == HDR) || (state_next == RUN);
         if (end_hit) begin
            scan_count_reg <= scan_count_reg + 16'd1;
         end

         if ((state_next == FAULT) && (state_reg != FAULT)) begin
            fault_reg      <= 1'b1;
            fault_code_reg <= fault_code_next;
         end
      end
   end

   assign restart      = (state_reg == RESTART);
   assign start_addr   = 16'(start_reg);
   assign hold_n       = hold_n_reg;
   assign instr_valid  = instr_valid_reg;
   assign instr_byte   = instr_byte_reg;
   assign scan_start   = scan_start_reg;
   assign scan_active  = scan_active_reg;
   assign scan_count   = scan_count_reg;
   assign fault        = fault_reg;
   assign fault_code   = fault_code_reg;
   assign trig_overrun = overrun_reg;

endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// Directed bench for vslc_scan_sequencer: header parse, forwarding scoreboard, restart pacing,
// trigger handling, hold_n back-pressure, async reset and header faults.
module tb_vslc_scan_sequencer;

   localparam int ADDR_W        = 10;
   localparam int MIN_PERIOD    = 16;
   localparam int RESTART_PULSE = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = '0;
   logic [15:0] byte_addr = '0;
   logic        exec_busy = 1'b0;
   logic        auto_mode = 1'b1;
   logic        ext_trigger = 1'b0;
   logic        restart;
   logic [15:0] start_addr;
   logic        hold_n;
   logic        instr_valid;
   logic [7:0]  instr_byte;
   logic        scan_start;
   logic        scan_active;
   logic [15:0] scan_count;
   logic        fault;
   logic [1:0]  fault_code;
   logic        trig_overrun;

   always #5 clk = ~clk;

   vslc_scan_sequencer #(
      .ADDR_W        (ADDR_W),
      .MIN_PERIOD    (MIN_PERIOD),
      .RESTART_PULSE (RESTART_PULSE)
`ifdef VSLC_SCAN_WDT_EN
      ,
      .WDT_CYCLES    (64)
`endif
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_addr    (byte_addr),
      .exec_busy    (exec_busy),
      .auto_mode    (auto_mode),
      .ext_trigger  (ext_trigger),
      .restart      (restart),
      .start_addr   (start_addr),
      .hold_n       (hold_n),
      .instr_valid  (instr_valid),
      .instr_byte   (instr_byte),
      .scan_start   (scan_start),
      .scan_active  (scan_active),
      .scan_count   (scan_count),
      .fault        (fault),
      .fault_code   (fault_code),
      .trig_overrun (trig_overrun)
   );

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int instr_cnt = 0;
   int restart_rises = 0;
   int scan_starts = 0;
   int last_scan_start_cyc = 0;
   logic restart_prev = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] prog [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Output monitor: scoreboard pops on every instruction strobe.
   initial begin
      logic [7:0] exp_b;
      forever begin
         @(negedge clk);
         if (instr_valid === 1'b1) begin
            instr_cnt++;
            tests_run++;
            assert (exp_q.size() != 0) else begin
               tests_failed++;
               $error("FAIL instr_unexpected: observed byte 0x%02h expected no strobe", instr_byte);
            end
            if (exp_q.size() != 0) begin
               exp_b = exp_q.pop_front();
               check("instr_byte", {24'd0, instr_byte}, {24'd0, exp_b});
               $display("[TB] cyc %0d instr 0x%02h (expected 0x%02h)", cyc, instr_byte, exp_b);
            end
         end
         if (scan_start === 1'b1) begin
            scan_starts++;
            last_scan_start_cyc = cyc;
            $display("[TB] cyc %0d scan_start", cyc);
         end
         if (restart === 1'b1 && restart_prev !== 1'b1) begin
            restart_rises++;
            $display("[TB] cyc %0d restart start_addr 0x%04h", cyc, start_addr);
         end
         restart_prev = restart;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "bench timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [15:0] addr, input logic [7:0] data, input logic fwd);
      int n = 0;
      while (hold_n !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("hold_n_before_byte", {31'd0, hold_n}, 32'd1);
      byte_valid = 1'b1;
      byte_addr  = addr;
      byte_data  = data;
      if (fwd) exp_q.push_back(data);
      tick();
      byte_valid = 1'b0;
      tick();
   endtask

   task automatic send_hdr(input logic [7:0] b0, b1, b2, b3);
      send_byte(16'd0, b0, 1'b0);
      send_byte(16'd1, b1, 1'b0);
      send_byte(16'd2, b2, 1'b0);
      send_byte(16'd3, b3, 1'b0);
   endtask

   task automatic send_prog();
      for (int i = 0; i < 4; i++) send_byte(16'(4 + i), prog[i], 1'b1);
   endtask

   task automatic wait_restart(input string tag, output int hi_cycles, output int rise_cyc);
      int n = 0;
      hi_cycles = 0;
      while (restart !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_restart_seen"}, {31'd0, restart}, 32'd1);
      check({tag, "_start_addr"}, {16'd0, start_addr}, 32'h0004);
      rise_cyc = cyc;
      while (restart === 1'b1 && hi_cycles < 10) begin
         hi_cycles++;
         tick();
      end
   endtask

   task automatic fault_case(input string tag, input logic [7:0] b1, b3, input logic [1:0] code);
      int r0, i0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      r0 = restart_rises;
      i0 = instr_cnt;
      send_hdr(8'h00, b1, 8'h00, b3);
      repeat (2) tick();
      check({tag, "_fault"}, {31'd0, fault}, 32'd1);
      check({tag, "_fault_code"}, {30'd0, fault_code}, {30'd0, code});
      send_byte(16'd8, 8'h55, 1'b0);
      repeat (20) tick();
      check({tag, "_no_restart"}, restart_rises, r0);
      check({tag, "_no_instr"}, instr_cnt, i0);
      check({tag, "_hold_n"}, {31'd0, hold_n}, 32'd1);
      check({tag, "_scan_active"}, {31'd0, scan_active}, 32'd0);
   endtask

   initial begin
      int hi, rc, r0;
      repeat (3) tick();
      check("rst_restart", {31'd0, restart}, 32'd0);
      check("rst_start_addr", {16'd0, start_addr}, 32'd0);
      check("rst_hold_n", {31'd0, hold_n}, 32'd1);
      check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_scan_start", {31'd0, scan_start}, 32'd0);
      check("rst_scan_active", {31'd0, scan_active}, 32'd0);
      check("rst_scan_count", {16'd0, scan_count}, 32'd0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      check("rst_fault_code", {30'd0, fault_code}, 32'd0);
      check("rst_trig_overrun", {31'd0, trig_overrun}, 32'd0);
      rst = 1'b0;
      tick();
      check("hdr_scan_active", {31'd0, scan_active}, 32'd1);

      // Scan 1: auto restart, rate limited.
      send_hdr(8'h00, 8'h04, 8'h00, 8'h07);
      check("hdr_start_addr", {16'd0, start_addr}, 32'h0004);
      send_prog();
      check("s1_scan_count", {16'd0, scan_count}, 32'd1);
      check("s1_instr_cnt", instr_cnt, 4);
      check("s1_scan_starts", scan_starts, 1);
      check("s1_scan_active_wait", {31'd0, scan_active}, 32'd0);
      wait_restart("s1", hi, rc);
      check("s1_restart_len", hi, RESTART_PULSE);
      check("s1_restart_period", {31'd0, (rc - last_scan_start_cyc) >= MIN_PERIOD}, 32'd1);

      // Scan 2: executor back-pressure; switch to triggered mode.
      auto_mode = 1'b0;
      send_byte(16'd4, prog[0], 1'b1);
      exec_busy = 1'b1;
      send_byte(16'd5, prog[1], 1'b1);
      check("busy_hold_n_low", {31'd0, hold_n}, 32'd0);
      repeat (2) tick();
      check("busy_hold_n_still_low", {31'd0, hold_n}, 32'd0);
      exec_busy = 1'b0;
      send_byte(16'd6, prog[2], 1'b1);
      send_byte(16'd7, prog[3], 1'b1);
      check("s2_instr_cnt", instr_cnt, 8);
      check("s2_scan_count", {16'd0, scan_count}, 32'd2);

      // Triggered mode idles in WAIT until an edge.
      r0 = restart_rises;
      repeat (40) tick();
      check("manual_no_restart", restart_rises, r0);
      check("manual_scan_active", {31'd0, scan_active}, 32'd0);
      ext_trigger = 1'b1;
      repeat (3) tick();
      ext_trigger = 1'b0;
      wait_restart("trig", hi, rc);
      check("trig_restart_cnt", restart_rises, r0 + 1);

      // Scan 3: two trigger edges while running.
      ext_trigger = 1'b1;
      send_byte(16'd4, prog[0], 1'b1);
      tick();
      ext_trigger = 1'b0;
      send_byte(16'd5, prog[1], 1'b1);
      tick();
      ext_trigger = 1'b1;
      send_byte(16'd6, prog[2], 1'b1);
      tick();
      ext_trigger = 1'b0;
      send_byte(16'd7, prog[3], 1'b1);
      repeat (3) tick();
      check("overrun_set", {31'd0, trig_overrun}, 32'd1);
      wait_restart("ovr", hi, rc);
      send_prog();
      repeat (40) tick();
      check("overrun_one_restart", restart_rises, r0 + 2);
      check("s4_scan_count", {16'd0, scan_count}, 32'd4);

      // Asynchronous reset in the middle of a scan.
      auto_mode = 1'b1;
      wait_restart("pre_rst", hi, rc);
      send_byte(16'd4, prog[0], 1'b1);
      send_byte(16'd5, prog[1], 1'b1);
      byte_valid = 1'b1;
      byte_addr  = 16'd6;
      byte_data  = prog[2];
      #2;
      rst = 1'b1;
      #1;
      check("arst_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("arst_hold_n", {31'd0, hold_n}, 32'd1);
      check("arst_scan_count", {16'd0, scan_count}, 32'd0);
      check("arst_trig_overrun", {31'd0, trig_overrun}, 32'd0);
      check("arst_start_addr", {16'd0, start_addr}, 32'd0);
      check("arst_scan_active", {31'd0, scan_active}, 32'd0);
      byte_valid = 1'b0;
      exp_q.delete();
      repeat (2) tick();
      rst = 1'b0;
      tick();
      r0 = scan_starts;
      send_hdr(8'h00, 8'h04, 8'h00, 8'h07);
      send_prog();
      check("reparse_scan_count", {16'd0, scan_count}, 32'd1);
      check("reparse_scan_start", scan_starts, r0 + 1);

      // Header faults.
      fault_case("hdr_end_lt_start", 8'h08, 8'h05, 2'd2);
      fault_case("hdr_end_zero", 8'h04, 8'h00, 2'd1);
      fault_case("hdr_start_lt4", 8'h02, 8'h07, 2'd2);

`ifdef VSLC_SCAN_WDT_EN
      begin
         int c0, n;
         rst = 1'b1;
         tick();
         rst = 1'b0;
         tick();
         send_hdr(8'h00, 8'h04, 8'h00, 8'h07);
         send_byte(16'd4, prog[0], 1'b1);
         c0 = cyc;
         n = 0;
         while (fault !== 1'b1 && n < 200) begin
            tick();
            n++;
         end
         check("wdt_fault", {31'd0, fault}, 32'd1);
         check("wdt_fault_code", {30'd0, fault_code}, 32'd3);
         check("wdt_timing", {31'd0, ((cyc - c0) >= 60) && ((cyc - c0) <= 70)}, 32'd1);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
